tty_msg_sequencer: RTL and testbench

//  Test-stimulus front end for the serial (KL8E) block on the FPGA test top. Emulates the CPU side
//  of a TTY driver: walks a message ROM, emits IOT instructions (TCF/TLS/TSF, optional KSF/KRB)
//  in step with the major-state sequencer and drives the AC value the serial block consumes.

---
 rtl/tty_msg_sequencer_pkg.sv | 20 ++
 rtl/tty_msg_rom.sv | 33 +++
 rtl/tty_msg_sequencer.sv | 162 ++++++++++++++++
 tb/tb_tty_msg_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tty_msg_sequencer_pkg.sv
// Shared IOT opcodes and major-state codes for the TTY message sequencer.
// Also holds a helper that forms the 12-bit AC image from a 7-bit ASCII character.
package tty_msg_sequencer_pkg;

   localparam logic [0:11] IOT_TCF = 12'o6042;
   localparam logic [0:11] IOT_TLS = 12'o6046;
   localparam logic [0:11] IOT_TSF = 12'o6041;
   localparam logic [0:11] IOT_KSF = 12'o6031;
   localparam logic [0:11] IOT_KRB = 12'o6036;
   localparam logic [0:11] IOT_NOP = 12'o7000;

   localparam logic [4:0] MS_F0 = 5'd1;
   localparam logic [4:0] MS_E0 = 5'd8;

   // Mark parity is added downstream, so the top five AC bits stay clear.
   function automatic logic [0:11] ac_of_char(input logic [6:0] ch);
      return {5'b00000, ch};
   endfunction

endpackage

// File: rtl/tty_msg_rom.sv
// Message ROM: character index in, 7-bit ASCII out ("HELLO, PDP-8/E" CR LF).
// Indices past the end of the text read as a space.
module tty_msg_rom
   import tty_msg_sequencer_pkg::*;
(
   input  logic [5:0] i_index,
   output logic [6:0] o_char
);

   always_comb begin
      o_char = 7'h20;
      case (i_index)
         6'd0:    o_char = 7'h48;
         6'd1:    o_char = 7'h45;
         6'd2:    o_char = 7'h4C;
         6'd3:    o_char = 7'h4C;
         6'd4:    o_char = 7'h4F;
         6'd5:    o_char = 7'h2C;
         6'd6:    o_char = 7'h20;
         6'd7:    o_char = 7'h50;
         6'd8:    o_char = 7'h44;
         6'd9:    o_char = 7'h50;
         6'd10:   o_char = 7'h2D;
         6'd11:   o_char = 7'h38;
         6'd12:   o_char = 7'h2F;
         6'd13:   o_char = 7'h45;
         6'd14:   o_char = 7'h0D;
         6'd15:   o_char = 7'h0A;
         default: o_char = 7'h20;
      endcase
   end

endmodule

// File: rtl/tty_msg_sequencer.sv
// CPU-side TTY driver emulation: walks the message ROM and issues TCF/TLS/TSF IOTs in step
// with the F0/E0 major states. Define ECHO_EN to interleave KSF/KRB and echo received characters.
module tty_msg_sequencer
   import tty_msg_sequencer_pkg::*;
#(
   parameter int MSG_LEN  = 16,
   parameter int GAP_CYC  = 1000,
   parameter int POLL_MAX = 65535
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic [4:0]  i_state,
   input  logic        i_skip,
   input  logic [0:11] i_rx_data,
   output logic [0:11] o_instruction,
   output logic [0:11] o_ac,
   output logic        o_msg_done,
   output logic        o_timeout,
   output logic [2:0]  o_dbg_state
);

   typedef enum logic [2:0] {
      S_CLR  = 3'd0,
      S_LOAD = 3'd1,
      S_POLL = 3'd2,
      S_GAP  = 3'd3,
      S_KSF  = 3'd4,
      S_KRB  = 3'd5,
      S_ECHO = 3'd6
   } fsm_t;

   localparam logic [5:0]  LAST_IDX = 6'(MSG_LEN - 1);
   localparam logic [16:0] POLL_LIM = 17'(POLL_MAX);
   localparam int          GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

   fsm_t             r_fsm;
   logic [0:11]      r_instruction;
   logic [0:11]      r_ac;
   logic             r_msg_done;
   logic             r_timeout;
   logic [5:0]       r_index;
   logic [15:0]      r_poll_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             r_armed;
   logic [6:0]       w_rom_char;
   logic             w_unused_rx;
`ifdef ECHO_EN
   logic [6:0]       r_echo_chr;
   logic             r_echo_act;
   assign w_unused_rx = ^i_rx_data[0:4];
`else
   assign w_unused_rx = ^i_rx_data;
`endif

   tty_msg_rom u_rom (
      .i_index (r_index),
      .o_char  (w_rom_char)
   );

   // r_armed marks that the last F0 presented the IOT belonging to r_fsm, so an E0 may
   // only advance the FSM for an instruction that was actually issued.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_fsm         <= S_CLR;
         r_instruction <= IOT_NOP;
         r_ac          <= '0;
         r_msg_done    <= 1'b0;
         r_timeout     <= 1'b0;
         r_index       <= '0;
         r_poll_cnt    <= '0;
         r_gap_cnt     <= '0;
         r_armed       <= 1'b0;
`ifdef ECHO_EN
         r_echo_chr    <= '0;
         r_echo_act    <= 1'b0;
`endif
      end else begin
         r_msg_done <= 1'b0;

         // The gap is timed in clocks, independent of the major-state sequence.
         if (r_fsm == S_GAP) begin
            if (r_gap_cnt == '0) r_fsm <= S_LOAD;
            else                 r_gap_cnt <= r_gap_cnt - 1'b1;
         end

         if (i_state == MS_F0) begin
            r_armed <= (r_fsm != S_GAP);
            case (r_fsm)
               S_CLR:  r_instruction <= IOT_TCF;
               S_LOAD: begin
                  r_instruction <= IOT_TLS;
                  r_ac          <= ac_of_char(w_rom_char);
               end
               S_POLL: r_instruction <= IOT_TSF;
`ifdef ECHO_EN
               S_KSF:  r_instruction <= IOT_KSF;
               S_KRB:  r_instruction <= IOT_KRB;
               S_ECHO: begin
                  r_instruction <= IOT_TLS;
                  r_ac          <= ac_of_char(r_echo_chr);
               end
`endif
               default: r_instruction <= IOT_NOP;
            endcase
         end else if ((i_state == MS_E0) && r_armed) begin
            r_armed <= 1'b0;
            case (r_fsm)
               S_CLR:  r_fsm <= S_LOAD;
               S_LOAD: begin
                  r_fsm      <= S_POLL;
                  r_poll_cnt <= '0;
               end
               S_POLL: begin
                  if (i_skip) begin
`ifdef ECHO_EN
                     if (r_echo_act) begin
                        r_echo_act <= 1'b0;
                        r_fsm      <= S_LOAD;
                     end else
`endif
                     if (r_index == LAST_IDX) begin
                        r_msg_done <= 1'b1;
                        r_index    <= '0;
                        r_gap_cnt  <= GAP_W'(GAP_CYC - 1);
                        r_fsm      <= (GAP_CYC == 0) ? S_LOAD : S_GAP;
                     end else begin
                        r_index <= r_index + 6'd1;
                        r_fsm   <= S_LOAD;
                     end
                  end else begin
                     if (r_poll_cnt != '1) r_poll_cnt <= r_poll_cnt + 16'd1;
                     if (({1'b0, r_poll_cnt} + 17'd1) >= POLL_LIM) r_timeout <= 1'b1;
`ifdef ECHO_EN
                     r_fsm <= S_KSF;
`endif
                  end
               end
`ifdef ECHO_EN
               S_KSF:  r_fsm <= i_skip ? S_KRB : S_POLL;
               S_KRB: begin
                  r_echo_chr <= i_rx_data[5:11];
                  r_fsm      <= S_ECHO;
               end
               S_ECHO: begin
                  r_echo_act <= 1'b1;
                  r_poll_cnt <= '0;
                  r_fsm      <= S_POLL;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign o_instruction = r_instruction;
   assign o_ac          = r_ac;
   assign o_msg_done    = r_msg_done;
   assign o_timeout     = r_timeout;
   assign o_dbg_state   = r_fsm;

endmodule

// File: tb/tb_tty_msg_sequencer.sv
// Self-checking bench for tty_msg_sequencer: drives F0/E0 instruction cycles, predicts each
// presented IOT/AC pair in a scoreboard queue. Echo scenario runs when ECHO_EN is defined.
module tb_tty_msg_sequencer;

   localparam int TB_MSG_LEN  = 6;
   localparam int TB_GAP      = 12;
   localparam int TB_POLL_MAX = 4;

   localparam logic [4:0]  MS_F0   = tty_msg_sequencer_pkg::MS_F0;
   localparam logic [4:0]  MS_E0   = tty_msg_sequencer_pkg::MS_E0;
   localparam logic [4:0]  MS_IDLE = 5'd0;

   localparam logic [0:11] B_TCF = 12'o6042;
   localparam logic [0:11] B_TLS = 12'o6046;
   localparam logic [0:11] B_TSF = 12'o6041;
   localparam logic [0:11] B_NOP = 12'o7000;
`ifdef ECHO_EN
   localparam logic [0:11] B_KSF = 12'o6031;
   localparam logic [0:11] B_KRB = 12'o6036;
`endif

   logic        clk;
   logic        reset;
   logic [4:0]  state;
   logic        skip;
   logic [0:11] rx_data;
   logic [0:11] instruction;
   logic [0:11] ac;
   logic        msg_done;
   logic        timeout;
   logic [2:0]  dbg_state;

   logic [23:0] exp_q[$];
   int          n_checks;
   int          n_pass;
   int          done_cnt;
   string       msg_text = "HELLO, PDP-8/E\r\n";

   tty_msg_sequencer #(
      .MSG_LEN  (TB_MSG_LEN),
      .GAP_CYC  (TB_GAP),
      .POLL_MAX (TB_POLL_MAX)
   ) dut (
      .i_clock       (clk),
      .i_reset       (reset),
      .i_state       (state),
      .i_skip        (skip),
      .i_rx_data     (rx_data),
      .o_instruction (instruction),
      .o_ac          (ac),
      .o_msg_done    (msg_done),
      .o_timeout     (timeout),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   always @(negedge clk) if (msg_done) done_cnt++;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0o, expected %0o (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [0:11] char_ac(input int idx);
      byte b;
      b = msg_text[idx];
      return {5'b00000, b[6:0]};
   endfunction

   function automatic logic [0:11] rnd_rx();
      return 12'($urandom_range(0, 4095));
   endfunction

   task automatic push(input logic [0:11] ins, input logic [0:11] acv);
      exp_q.push_back({ins, acv});
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic [4:0] st, input logic sk, input logic [0:11] rx);
      state   = st;
      skip    = sk;
      rx_data = rx;
   endtask

   // One instruction cycle: F0, E0, two idle clocks. Called at a falling edge.
   task automatic run_cycle(input logic skip_e0, input logic [0:11] rx_e0);
      logic [23:0] e;
      logic        have;
      e    = '0;
      have = 1'b0;
      drive(MS_F0, 1'($urandom_range(0, 1)), rnd_rx());
      @(negedge clk);
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
         e    = exp_q.pop_front();
         have = 1'b1;
         check("instr", instruction, e[23:12]);
         check("ac", ac, e[11:0]);
      end
      drive(MS_E0, skip_e0, rx_e0);
      @(negedge clk);
      drive(MS_IDLE, 1'($urandom_range(0, 1)), rnd_rx());
      @(negedge clk);
      @(negedge clk);
      if (have) begin
         check("instr_hold", instruction, e[23:12]);
         check("ac_hold", ac, e[11:0]);
      end
   endtask

   task automatic send_char(input int idx, input int n_wait);
      logic [0:11] c;
      c = char_ac(idx);
      push(B_TLS, c);
      run_cycle(1'($urandom_range(0, 1)), rnd_rx());
      for (int p = 0; p < n_wait; p++) begin
         push(B_TSF, c);
         run_cycle(1'b0, rnd_rx());
`ifdef ECHO_EN
         push(B_KSF, c);
         run_cycle(1'b0, rnd_rx());
`endif
      end
      push(B_TSF, c);
      run_cycle(1'b1, rnd_rx());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [0:11] c;
      n_checks = 0;
      n_pass   = 0;
      done_cnt = 0;
      reset    = 1'b1;
      drive(MS_IDLE, 1'b0, '0);
      repeat (3) @(negedge clk);
      check("rst_instr", instruction, B_NOP);
      check("rst_ac", ac, 0);
      check("rst_msg_done", msg_done, 0);
      check("rst_timeout", timeout, 0);
      reset = 1'b0;
      @(negedge clk);

      // Start of message, skip tied high: TCF, then TLS 'H' (0110), TSF, next character.
      push(B_TCF, 12'o0000);
      run_cycle(1'b1, rnd_rx());
      check("first_char_is_H", char_ac(0), 12'o0110);
      send_char(0, 0);
      send_char(1, 0);

      // Slow transmitter: several non-skipping polls below the timeout limit.
      send_char(2, 3);
      check("no_timeout_3_polls", timeout, 0);
      for (int i = 3; i < TB_MSG_LEN - 1; i++) send_char(i, 0);
      check("done_before_last", done_cnt, 0);
      send_char(TB_MSG_LEN - 1, 0);
      check("done_after_last", done_cnt, 1);

      // Gap: any F0 that falls within TB_GAP clocks of the final E0 presents a NOP.
      // F0s land 3, 7, 11 ... clocks after that E0.
      c = char_ac(TB_MSG_LEN - 1);
      for (int d = 3; d <= TB_GAP; d += 4) begin
         push(B_NOP, c);
         run_cycle(1'b1, rnd_rx());
      end
      send_char(0, 0);
      check("done_single_pulse", done_cnt, 1);
      send_char(1, 0);
      send_char(2, 0);

      // Reset while polling character 3, then restart via TCF at index 0.
      c = char_ac(3);
      push(B_TLS, c);
      run_cycle(1'b0, rnd_rx());
      push(B_TSF, c);
      run_cycle(1'b0, rnd_rx());
`ifdef ECHO_EN
      push(B_KSF, c);
      run_cycle(1'b0, rnd_rx());
`endif
      drive(MS_F0, 1'b1, rnd_rx());
      reset = 1'b1;
      @(negedge clk);
      check("midrst_instr", instruction, B_NOP);
      check("midrst_ac", ac, 0);
      drive(MS_IDLE, 1'b0, '0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      push(B_TCF, 12'o0000);
      run_cycle(1'b1, rnd_rx());
      send_char(0, 0);

      // Timeout: sets on the POLL_MAX-th non-skipping TSF, sticky, polling continues.
      c = char_ac(1);
      push(B_TLS, c);
      run_cycle(1'b1, rnd_rx());
      for (int p = 1; p <= TB_POLL_MAX + 1; p++) begin
         push(B_TSF, c);
         run_cycle(1'b0, rnd_rx());
`ifdef ECHO_EN
         push(B_KSF, c);
         run_cycle(1'b0, rnd_rx());
`endif
         check("timeout_poll", timeout, (p >= TB_POLL_MAX) ? 1 : 0);
      end
      push(B_TSF, c);
      run_cycle(1'b1, rnd_rx());
      check("timeout_sticky", timeout, 1);

`ifdef ECHO_EN
      // Echo: KSF skips, KRB reads 0301, echoed TLS carries 0101, message resumes at index 2.
      c = char_ac(2);
      push(B_TLS, c);
      run_cycle(1'b1, rnd_rx());
      push(B_TSF, c);
      run_cycle(1'b0, rnd_rx());
      push(B_KSF, c);
      run_cycle(1'b1, rnd_rx());
      push(B_KRB, c);
      run_cycle(1'($urandom_range(0, 1)), 12'o0301);
      push(B_TLS, 12'o0101);
      run_cycle(1'b1, rnd_rx());
      push(B_TSF, 12'o0101);
      run_cycle(1'b1, rnd_rx());
      send_char(2, 0);
`else
      send_char(2, 0);
`endif
      check("timeout_still_set", timeout, 1);
      send_char(3, 0);

      reset = 1'b1;
      @(negedge clk);
      check("final_rst_timeout", timeout, 0);
      check("final_rst_instr", instruction, B_NOP);
      reset = 1'b0;
      check("sb_drain", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
